// File: rtl/branch_pkg.sv
// Shared types for the execute-stage branch resolver: op encoding, FSM states, PC step.
package branch_pkg;

   // Encoding matches RV32I funct3 for branches; 2/3 are reused for JAL/JALR.
   typedef enum logic [2:0] {
      BEQ  = 3'd0,
      BNE  = 3'd1,
      JAL  = 3'd2,
      JALR = 3'd3,
      BLT  = 3'd4,
      BGE  = 3'd5,
      BLTU = 3'd6,
      BGEU = 3'd7
   } br_op_t;

   typedef enum logic [1:0] {
      IDLE,
      RESOLVE,
      HOLD
   } state_t;

   localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition, target and mispredict evaluation for one decoded op.
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  br_op_t            op_i,
   input  logic [XLEN-1:0]   pc_i,
   input  logic [XLEN-1:0]   imm_i,
   input  logic [XLEN-1:0]   rs1_i,
   input  logic [XLEN-1:0]   rs2_i,
   input  logic              pred_taken_i,
   input  logic [XLEN-1:0]   pred_target_i,
   output logic              taken_o,
   output logic [XLEN-1:0]   target_o,
   output logic [XLEN-1:0]   correct_pc_o,
   output logic [XLEN-1:0]   link_pc_o,
   output logic              mispredict_o
);

   logic [XLEN:0]   diff;
   logic            eq;
   logic            ltu;
   logic            lt;
   logic [XLEN-1:0] jalr_sum;

   // Single subtractor shared by all compares; carry-out set means rs1 >= rs2 unsigned.
   assign diff     = {1'b0, rs1_i} + {1'b0, ~rs2_i} + (XLEN+1)'(1);
   assign eq       = (diff[XLEN-1:0] == '0);
   assign ltu      = !diff[XLEN];
   assign lt       = (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]) ? rs1_i[XLEN-1] : diff[XLEN-1];
   assign jalr_sum = rs1_i + imm_i;

   always_comb begin
      taken_o  = 1'b0;
      target_o = pc_i + imm_i;
      case (op_i)
         BEQ:     taken_o = eq;
         BNE:     taken_o = !eq;
         BLT:     taken_o = lt;
         BGE:     taken_o = !lt;
         BLTU:    taken_o = ltu;
         BGEU:    taken_o = !ltu;
         JAL:     taken_o = 1'b1;
         JALR: begin
            taken_o  = 1'b1;
            target_o = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
         end
         default: taken_o = 1'b0;
      endcase
   end

   assign link_pc_o    = pc_i + XLEN'(PC_STEP);
   assign correct_pc_o = taken_o ? target_o : link_pc_o;
   assign mispredict_o = (pred_taken_i != taken_o) || (taken_o && (pred_target_i != target_o));

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: one registered stage from issue to result/redirect/flush.
// Define BRANCH_STATS_EN to add saturating branch/taken/mispredict counters.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int unsigned XLEN   = 32
`ifdef BRANCH_STATS_EN
   ,
   parameter int unsigned STAT_W = 32
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  br_op_t            in_op,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   input  logic              in_pred_taken,
   input  logic [XLEN-1:0]   in_pred_target,
   output logic              redir_valid,
   input  logic              redir_ready,
   output logic [XLEN-1:0]   redir_pc,
   output logic              flush,
   output logic [XLEN-1:0]   link_pc,
   output logic              res_valid,
   output logic              res_taken
`ifdef BRANCH_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_taken,
   output logic [STAT_W-1:0] stat_mispred
`endif
);

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              redir_valid_q, redir_valid_d;
   logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
   logic              flush_q, flush_d;
   logic [XLEN-1:0]   link_pc_q, link_pc_d;
   logic              res_valid_q, res_valid_d;
   logic              res_taken_q, res_taken_d;
   logic              accept;

   logic              ev_taken;
   logic [XLEN-1:0]   ev_target;
   logic [XLEN-1:0]   ev_correct_pc;
   logic [XLEN-1:0]   ev_link_pc;
   logic              ev_mispredict;

   branch_cond_eval #(.XLEN(XLEN)) u_cond (
      .op_i          (in_op),
      .pc_i          (in_pc),
      .imm_i         (in_imm),
      .rs1_i         (in_rs1),
      .rs2_i         (in_rs2),
      .pred_taken_i  (in_pred_taken),
      .pred_target_i (in_pred_target),
      .taken_o       (ev_taken),
      .target_o      (ev_target),
      .correct_pc_o  (ev_correct_pc),
      .link_pc_o     (ev_link_pc),
      .mispredict_o  (ev_mispredict)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b1;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         flush_q       <= 1'b0;
         link_pc_q     <= '0;
         res_valid_q   <= 1'b0;
         res_taken_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         flush_q       <= flush_d;
         link_pc_q     <= link_pc_d;
         res_valid_q   <= res_valid_d;
         res_taken_q   <= res_taken_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      redir_valid_d = redir_valid_q;
      redir_pc_d    = redir_pc_q;
      flush_d       = 1'b0;
      link_pc_d     = link_pc_q;
      res_valid_d   = 1'b0;
      res_taken_d   = res_taken_q;
      accept        = 1'b0;

      case (state_q)
         IDLE: accept = in_valid && in_ready_q;
         RESOLVE: begin
            if (redir_valid_q) begin
               if (redir_ready) begin
                  redir_valid_d = 1'b0;
                  state_d       = IDLE;
               end else begin
                  state_d = HOLD;
               end
            end else begin
               state_d = IDLE;
               accept  = in_valid && in_ready_q;
            end
         end
         HOLD: begin
            if (redir_ready) begin
               redir_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Accept only happens with no redirect outstanding, so it never clobbers one.
      if (accept) begin
         state_d     = RESOLVE;
         res_valid_d = 1'b1;
         res_taken_d = ev_taken;
         link_pc_d   = ev_link_pc;
         if (ev_mispredict) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = ev_correct_pc;
            flush_d       = 1'b1;
         end
      end

      in_ready_d = !redir_valid_d;
   end

   assign in_ready    = in_ready_q;
   assign redir_valid = redir_valid_q;
   assign redir_pc    = redir_pc_q;
   assign flush       = flush_q;
   assign link_pc     = link_pc_q;
   assign res_valid   = res_valid_q;
   assign res_taken   = res_taken_q;

`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0] stat_branches_q, stat_taken_q, stat_mispred_q;

   // Counters trail the result pulse by one cycle; flush marks exactly one per mispredict.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_q <= '0;
         stat_taken_q    <= '0;
         stat_mispred_q  <= '0;
      end else begin
         if (res_valid_q && (stat_branches_q != '1))
            stat_branches_q <= stat_branches_q + STAT_W'(1);
         if (res_valid_q && res_taken_q && (stat_taken_q != '1))
            stat_taken_q <= stat_taken_q + STAT_W'(1);
         if (flush_q && (stat_mispred_q != '1))
            stat_mispred_q <= stat_mispred_q + STAT_W'(1);
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_taken    = stat_taken_q;
   assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed ops push expectations, a negedge monitor checks results.
module tb_branch_resolve_unit;
   import branch_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   br_op_t      in_op;
   logic [31:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_target;
   logic        in_pred_taken;
   logic        redir_valid;
   logic        redir_ready;
   logic [31:0] redir_pc;
   logic        flush;
   logic [31:0] link_pc;
   logic        res_valid;
   logic        res_taken;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches, stat_taken, stat_mispred;
`endif

   branch_resolve_unit dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_op          (in_op),
      .in_pc          (in_pc),
      .in_imm         (in_imm),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_pred_taken  (in_pred_taken),
      .in_pred_target (in_pred_target),
      .redir_valid    (redir_valid),
      .redir_ready    (redir_ready),
      .redir_pc       (redir_pc),
      .flush          (flush),
      .link_pc        (link_pc),
      .res_valid      (res_valid),
      .res_taken      (res_taken)
`ifdef BRANCH_STATS_EN
      ,
      .stat_branches  (stat_branches),
      .stat_taken     (stat_taken),
      .stat_mispred   (stat_mispred)
`endif
   );

   typedef struct packed {
      logic        taken;
      logic        mis;
      logic [31:0] link;
      logic [31:0] redir;
   } exp_t;

   exp_t q[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   res_cnt  = 0;
   int   redir_cnt = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
   endfunction

   // Monitor: pops one expectation per result pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (redir_valid) redir_cnt++;
         if (res_valid) begin
            res_cnt++;
            if (q.size() == 0) begin
               check("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
               e = q.pop_front();
               check("res_taken", 32'(res_taken), 32'(e.taken));
               check("link_pc", link_pc, e.link);
               check("flush", 32'(flush), 32'(e.mis));
               check("redir_valid", 32'(redir_valid), 32'(e.mis));
               if (e.mis) check("redir_pc", redir_pc, e.redir);
            end
         end else if (flush) begin
            check("flush_without_res", 32'(flush), 32'd0);
         end
      end
   end

   task automatic issue(input br_op_t op, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic pt,
                        input logic [31:0] ptgt, input logic et, input logic em,
                        input logic [31:0] eredir);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_pc = pc; in_imm = imm;
      in_rs1 = rs1; in_rs2 = rs2; in_pred_taken = pt; in_pred_target = ptgt;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("issue_timeout_in_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      q.push_back('{et, em, pc + 32'd4, eredir});
      @(posedge clk);
      acc_cyc = cyc;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      int r0, d0, first_acc;
      rst = 1'b1; in_valid = 1'b0; redir_ready = 1'b1; in_op = BEQ;
      in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
      in_pred_taken = 1'b0; in_pred_target = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_redir_valid", 32'(redir_valid), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_taken", 32'(res_taken), 32'd0);
      check("rst_redir_pc", redir_pc, 32'd0);
      check("rst_link_pc", link_pc, 32'd0);
      rst = 1'b0;

      // Directed ops: condition, target and prediction compare.
      issue(BEQ,  32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 1'b1, 32'h120);
      issue(BLT,  32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h210, 1'b1, 1'b0, 32'h0);
      issue(BLTU, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h210, 1'b0, 1'b1, 32'h204);
      issue(JALR, 32'h40, 32'h0, 32'h1003, 32'h0, 1'b1, 32'h1002, 1'b1, 1'b0, 32'h0);
      issue(JALR, 32'h40, 32'h0, 32'h1003, 32'h0, 1'b1, 32'h1003, 1'b1, 1'b1, 32'h1002);
      issue(BNE,  32'h880, 32'h40, 32'd7, 32'd7, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      issue(BGE,  32'h800, 32'hFFFF_FFF0, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h7F0, 1'b1, 1'b0, 32'h0);
      issue(JAL,  32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
      issue(BGEU, 32'h900, 32'h100, 32'd0, 32'd0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA00);
      idle(4);

      // Back-to-back correctly predicted ops.
      r0 = res_cnt; d0 = redir_cnt; first_acc = 0;
      for (int i = 0; i < 10; i++) begin
         issue(BEQ, 32'h1000 + 32'(8*i), 32'h8, 32'(i), 32'(i), 1'b1, 32'h1008 + 32'(8*i),
               1'b1, 1'b0, 32'h0);
         if (i == 0) first_acc = acc_cyc;
      end
      check("b2b_accept_span", 32'(acc_cyc - first_acc), 32'd9);
      idle(4);
      check("b2b_res_pulses", 32'(res_cnt - r0), 32'd10);
      check("b2b_redirects", 32'(redir_cnt - d0), 32'd0);

      // Mispredict with fetch back-pressure and a stalled younger op.
      redir_ready = 1'b0;
      issue(BNE, 32'h2F0, 32'h40, 32'd1, 32'd2, 1'b0, 32'h0, 1'b1, 1'b1, 32'h330);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("hold_redir_valid", 32'(redir_valid), 32'd1);
         check("hold_redir_pc", redir_pc, 32'h330);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_flush", 32'(flush), (i == 0) ? 32'd1 : 32'd0);
         if (i == 0) begin
            in_valid = 1'b1; in_op = BEQ; in_pc = 32'h300; in_imm = 32'h8;
            in_rs1 = 32'd3; in_rs2 = 32'd3; in_pred_taken = 1'b1; in_pred_target = 32'h308;
            q.push_back('{1'b1, 1'b0, 32'h304, 32'h0});
         end
         if (i == 3) redir_ready = 1'b1;
      end
      @(negedge clk);
      check("post_hs_redir_valid", 32'(redir_valid), 32'd0);
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("queued_res_valid", 32'(res_valid), 32'd1);
      idle(3);

      // Reset while holding a redirect.
      redir_ready = 1'b0;
      issue(BEQ, 32'h500, 32'h10, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 1'b1, 32'h510);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_redir_valid", 32'(redir_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_hold_redir_valid", 32'(redir_valid), 32'd0);
      check("rst_hold_in_ready", 32'(in_ready), 32'd1);
      check("rst_hold_flush", 32'(flush), 32'd0);
`ifdef BRANCH_STATS_EN
      check("rst_stat_branches", stat_branches, 32'd0);
      check("rst_stat_taken", stat_taken, 32'd0);
      check("rst_stat_mispred", stat_mispred, 32'd0);
`endif
      rst = 1'b0;
      redir_ready = 1'b1;
      issue(BEQ, 32'h600, 32'h10, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 1'b1, 32'h610);
      issue(BNE, 32'h700, 32'h10, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      idle(4);
`ifdef BRANCH_STATS_EN
      check("stat_branches", stat_branches, 32'd2);
      check("stat_taken", stat_taken, 32'd1);
      check("stat_mispred", stat_mispred, 32'd1);
`endif
      check("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
